// File: rtl/si_pkg.sv
// Shared Space Invaders definitions: score width, game-phase encoding and
// default point values used by the score, display and collision logic.
package si_pkg;

    localparam int SCORE_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_OVER    = 2'd2
    } state_t;

    localparam int MAX_SCORE_DEF = 999;
    localparam int PTS_ROW0_DEF  = 10;
    localparam int PTS_ROW1_DEF  = 20;
    localparam int PTS_ROW2_DEF  = 30;
    localparam int PTS_ROW3_DEF  = 40;

endpackage

// File: rtl/placar_sat_add.sv
// Combinational saturating adder: a + b clamped to MAX, never wraps.
// Shared by the score, lives and level counters.
module sat_add
    import si_pkg::*;
#(
    parameter int W   = SCORE_W,
    parameter int MAX = MAX_SCORE_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    localparam logic [W:0] MAX_EXT = (W+1)'(MAX);

    // One extra bit so the carry out of the W-bit sum is never lost.
    logic [W:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};
    assign sum = (raw > MAX_EXT) ? MAX_EXT[W-1:0] : raw[W-1:0];

endmodule

// File: rtl/placar.sv
// Score and high-score keeper: turns alien hits and game start/end pulses
// into the current score, the high score and the game-phase flags.
module placar
    import si_pkg::*;
#(
    parameter int MAX_SCORE = MAX_SCORE_DEF,
    parameter int PTS_ROW0  = PTS_ROW0_DEF,
    parameter int PTS_ROW1  = PTS_ROW1_DEF,
    parameter int PTS_ROW2  = PTS_ROW2_DEF,
    parameter int PTS_ROW3  = PTS_ROW3_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               hit_valid,
    input  logic [1:0]         hit_row,
    input  logic               game_over,
    output logic [SCORE_W-1:0] pontuacao,
    output logic [SCORE_W-1:0] record,
    output logic               jogando,
    output logic               novo_record
);

    localparam int PTS [4] = '{PTS_ROW0, PTS_ROW1, PTS_ROW2, PTS_ROW3};

    state_t             state_reg, state_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [SCORE_W-1:0] record_reg, record_next;
    logic               novo_reg, novo_next;
    logic               jogando_reg, jogando_next;

    logic [SCORE_W-1:0] pts_table [4];
    logic [SCORE_W-1:0] sum_sat;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pts
            assign pts_table[gi] = SCORE_W'(PTS[gi]);
        end
    endgenerate

    sat_add #(
        .W   (SCORE_W),
        .MAX (MAX_SCORE)
    ) u_sat_add (
        .a   (score_reg),
        .b   (pts_table[hit_row]),
        .sum (sum_sat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            score_reg   <= '0;
            record_reg  <= '0;
            novo_reg    <= 1'b0;
            jogando_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            score_reg   <= score_next;
            record_reg  <= record_next;
            novo_reg    <= novo_next;
            jogando_reg <= jogando_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        score_next  = score_reg;
        record_next = record_reg;
        novo_next   = novo_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_PLAYING;
                    score_next = '0;
                end
            end
            ST_PLAYING: begin
                if (hit_valid) begin
                    score_next = sum_sat;
                end
                // A hit in the same cycle as game_over counts toward the record.
                if (game_over) begin
                    state_next = ST_OVER;
                    novo_next  = (score_next > record_reg);
                    if (score_next > record_reg) begin
                        record_next = score_next;
                    end
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_next = ST_PLAYING;
                    score_next = '0;
                    novo_next  = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        jogando_next = (state_next == ST_PLAYING);
    end

    assign pontuacao   = score_reg;
    assign record      = record_reg;
    assign jogando     = jogando_reg;
    assign novo_record = novo_reg;

endmodule

// File: tb/tb_placar.sv
// Self-checking bench for placar: directed scenarios with literal expectations,
// then randomized play compared every cycle against a behavioural game model.
module tb_placar;

    localparam int MAXS = 999;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        hit_valid = 1'b0;
    logic [1:0]  hit_row = 2'd0;
    logic        game_over = 1'b0;
    logic [11:0] pontuacao;
    logic [11:0] record;
    logic        jogando;
    logic        novo_record;

    int checks = 0;
    int errors = 0;

    placar dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .hit_valid   (hit_valid),
        .hit_row     (hit_row),
        .game_over   (game_over),
        .pontuacao   (pontuacao),
        .record      (record),
        .jogando     (jogando),
        .novo_record (novo_record)
    );

    always #10 clk = ~clk;

    // Behavioural model: game phase, score, best score, new-best flag.
    localparam int P_IDLE = 0, P_PLAY = 1, P_OVER = 2;
    int m_phase, m_score, m_rec, m_new;

    function automatic int points(input logic [1:0] row);
        return 10 * (int'(row) + 1);
    endfunction

    function automatic int after_hit(input int sc, input logic hv, input logic [1:0] row);
        int s;
        s = sc;
        if (hv) s = sc + points(row);
        if (s > MAXS) s = MAXS;
        return s;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= P_IDLE;
            m_score <= 0;
            m_rec   <= 0;
            m_new   <= 0;
        end else begin
            case (m_phase)
                P_IDLE: if (start) begin
                    m_phase <= P_PLAY;
                    m_score <= 0;
                end
                P_PLAY: begin
                    m_score <= after_hit(m_score, hit_valid, hit_row);
                    if (game_over) begin
                        m_phase <= P_OVER;
                        if (after_hit(m_score, hit_valid, hit_row) > m_rec) begin
                            m_rec <= after_hit(m_score, hit_valid, hit_row);
                            m_new <= 1;
                        end else begin
                            m_new <= 0;
                        end
                    end
                end
                default: if (start) begin
                    m_phase <= P_PLAY;
                    m_score <= 0;
                    m_new   <= 0;
                end
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("model_pontuacao", int'(pontuacao), m_score);
        chk("model_record", int'(record), m_rec);
        chk("model_jogando", int'(jogando), (m_phase == P_PLAY) ? 1 : 0);
        chk("model_novo", int'(novo_record), m_new);
    end

    // Apply one cycle of inputs; returns at the following negedge.
    task automatic drive(input logic s, input logic h, input logic [1:0] r, input logic g);
        start = s; hit_valid = h; hit_row = r; game_over = g;
        @(negedge clk);
        start = 0; hit_valid = 0; hit_row = 0; game_over = 0;
    endtask

    task automatic pulse_reset();
        #2 reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        @(negedge clk);
        chk("rst_pontuacao", int'(pontuacao), 0);
        chk("rst_record", int'(record), 0);
        chk("rst_jogando", int'(jogando), 0);
        chk("rst_novo", int'(novo_record), 0);
        reset = 0;
        @(negedge clk);

        // Hits in IDLE are ignored.
        drive(0, 1, 2'd3, 0);
        chk("idle_hit", int'(pontuacao), 0);

        // First hits.
        drive(1, 0, 0, 0);
        chk("start_jogando", int'(jogando), 1);
        drive(0, 1, 2'd0, 0); chk("hit_r0", int'(pontuacao), 10);
        drive(0, 1, 2'd1, 0); chk("hit_r1", int'(pontuacao), 30);
        drive(0, 1, 2'd3, 0); chk("hit_r3", int'(pontuacao), 70);
        chk("play_jogando", int'(jogando), 1);

        // Climb to 980, then saturate.
        for (int i = 0; i < 22; i++) drive(0, 1, 2'd3, 0);
        drive(0, 1, 2'd2, 0);
        chk("score_980", int'(pontuacao), 980);
        drive(0, 1, 2'd3, 0); chk("sat_999", int'(pontuacao), 999);
        drive(0, 1, 2'd0, 0); chk("sat_hold", int'(pontuacao), 999);

        // Hit together with game_over at score 50.
        pulse_reset();
        drive(1, 0, 0, 0);
        drive(0, 1, 2'd3, 0);
        drive(0, 1, 2'd0, 0);
        chk("score_50", int'(pontuacao), 50);
        drive(0, 1, 2'd2, 1);
        chk("go_pontuacao", int'(pontuacao), 80);
        chk("go_record", int'(record), 80);
        chk("go_jogando", int'(jogando), 0);
        chk("go_novo", int'(novo_record), 1);

        // Hit in OVER is ignored.
        drive(0, 1, 2'd3, 0);
        chk("over_hit", int'(pontuacao), 80);

        // Lower second game.
        drive(1, 0, 0, 0);
        chk("restart_score", int'(pontuacao), 0);
        chk("restart_novo", int'(novo_record), 0);
        drive(0, 1, 2'd3, 0);
        drive(0, 0, 0, 1);
        chk("g2_pontuacao", int'(pontuacao), 40);
        chk("g2_record", int'(record), 80);
        chk("g2_novo", int'(novo_record), 0);
        drive(1, 0, 0, 0);
        chk("g3_score", int'(pontuacao), 0);
        chk("g3_record", int'(record), 80);

        // start + game_over in PLAYING: game ends.
        drive(1, 0, 0, 1);
        chk("start_go_jogando", int'(jogando), 0);
        drive(0, 1, 2'd1, 0);
        chk("start_go_hold", int'(pontuacao), 0);

        // Asynchronous reset mid-game.
        drive(1, 0, 0, 0);
        drive(0, 1, 2'd2, 0);
        chk("mid_score", int'(pontuacao), 30);
        #3 reset = 1;
        #1;
        chk("async_pontuacao", int'(pontuacao), 0);
        chk("async_record", int'(record), 0);
        chk("async_jogando", int'(jogando), 0);
        chk("async_novo", int'(novo_record), 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                pulse_reset();
            end else begin
                drive(($urandom_range(0, 19) == 0),
                      ($urandom_range(0, 1) == 1),
                      2'($urandom_range(0, 3)),
                      ($urandom_range(0, 39) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
